// File: rtl/d_flip_flop.sv
// Positive-edge D register chain: WIDTH bits wide, STAGES deep, async active-high reset.
// Latency: STAGES rising edges from d to q; q is driven only by the last stage.
// Backpressure: none; every edge captures d, so one new value is accepted per clock.
module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Reset flushes every stage so no pre-reset sample can reach q afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VALUE;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: default instance via a vector table, 8x3 instance via a delay-queue scoreboard.
module tb_d_flip_flop;

    logic       clk;
    logic       rst0;
    logic       d0;
    logic       q0;
    logic       rst1;
    logic [7:0] d1;
    logic [7:0] q1;

    int compared;
    int mismatched;

    typedef struct {
        logic rst;
        logic d;
        logic q;
    } vec_t;

    vec_t       vecs [14];
    logic       exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] vals1 [8];

    d_flip_flop dut0 (
        .clk   (clk),
        .reset (rst0),
        .d     (d0),
        .q     (q0)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (8'hA5)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .d     (d1),
        .q     (q1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [7:0] e;
        compared   = 0;
        mismatched = 0;
        rst0 = 1'b1;
        d0   = 1'b0;
        rst1 = 1'b1;
        d1   = 8'h00;

        // {reset, d, expected q after the following edge}
        vecs[0]  = '{1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0};

        vals1[0] = 8'h3C; vals1[1] = 8'h01; vals1[2] = 8'h02; vals1[3] = 8'h5A;
        vals1[4] = 8'hFF; vals1[5] = 8'h80; vals1[6] = 8'h7E; vals1[7] = 8'h00;

        // Default instance; the wide instance sits in reset with d toggling.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst0 = vecs[i].rst;
            d0   = vecs[i].d;
            d1   = 8'(i * 8'h17);
            exp_q0.push_back(vecs[i].q);
            @(posedge clk);
            #1;
            e = {7'b0, exp_q0.pop_front()};
            check($sformatf("vec%0d", i), {7'b0, q0}, e);
            check($sformatf("p_rst_hold%0d", i), q1, 8'hA5);
        end

        // Short d pulse between edges must not be captured.
        @(negedge clk);
        #1 d0 = 1'b1;
        #2 d0 = 1'b0;
        @(posedge clk);
        #1 check("glitch_hi", {7'b0, q0}, 8'h00);
        @(negedge clk);
        d0 = 1'b1;
        @(posedge clk);
        #1 check("glitch_base", {7'b0, q0}, 8'h01);
        @(negedge clk);
        #1 d0 = 1'b0;
        #2 d0 = 1'b1;
        @(posedge clk);
        #1 check("glitch_lo", {7'b0, q0}, 8'h01);

        // Asynchronous reset between edges while q = 1.
        #1 rst0 = 1'b1;
        #1 check("async_rst", {7'b0, q0}, 8'h00);
        #1 check("async_rst_hold", {7'b0, q0}, 8'h00);
        @(negedge clk);
        rst0 = 1'b0;
        d0   = 1'b1;
        @(posedge clk);
        #1 check("post_rst", {7'b0, q0}, 8'h01);

        // Wide instance: release and stream through three stages.
        exp_q1.delete();
        exp_q1.push_back(8'hA5);
        exp_q1.push_back(8'hA5);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            rst1 = 1'b0;
            d1   = vals1[j];
            exp_q1.push_back(vals1[j]);
            @(posedge clk);
            #1 check($sformatf("p_stream%0d", j), q1, exp_q1.pop_front());
        end

        // Mid-stream reset must flush all in-flight data.
        #1 rst1 = 1'b1;
        #1 check("p_async", q1, 8'hA5);
        @(negedge clk);
        rst1 = 1'b0;
        exp_q1.delete();
        exp_q1.push_back(8'hA5);
        exp_q1.push_back(8'hA5);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            d1 = 8'hC0 + 8'(j);
            exp_q1.push_back(d1);
            @(posedge clk);
            #1 check($sformatf("p_flush%0d", j), q1, exp_q1.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
